// File: rtl/aoc5_load_phase.sv
// Ping-memory writer: packs a valid/ready tuple stream into even/odd bank pairs.
// Optional macro AOC5_LOAD_PAD_EN pads the region with all-ones pairs to a 16-tuple boundary.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 12
`endif

package aoc5_load_pkg;
    typedef struct packed {
        logic [15:0] key;
        logic [15:0] value;
    } tuple_pair_t;
endpackage

module aoc5_load_phase
    import aoc5_load_pkg::*;
#(
    parameter int unsigned MAX_TUPLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_in,
    input  tuple_pair_t                 tuple_in,
    input  logic                        tuple_valid_in,
    input  logic                        tuple_last_in,
    output logic                        tuple_ready_out,
    output logic [`BANK_ADDR_WIDTH-1:0] ping_addr_out,
    output tuple_pair_t                 even_data_out,
    output tuple_pair_t                 odd_data_out,
    output logic                        ping_write_en,
    output logic [31:0]                 stream_len_out,
    output logic                        load_done_out,
    output logic                        overflow_out
);
    localparam int AW = `BANK_ADDR_WIDTH;
    localparam logic [31:0] MAX_COUNT = 32'(MAX_TUPLES);
    localparam logic [AW-1:0] ADDR_STEP = AW'(2);
    localparam tuple_pair_t ALL_ONES = {$bits(tuple_pair_t){1'b1}};

`ifdef AOC5_LOAD_PAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, PAD = 2'd2, DONE = 2'd3} state_t;
    localparam state_t TAIL = PAD;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, DONE = 2'd2} state_t;
    localparam state_t TAIL = DONE;
`endif

    state_t        state_r, state_next;
    logic [31:0]   count_r;
    logic [AW-1:0] wr_addr_r;
    logic [AW-1:0] wr_addr_plus2_s;
    logic          half_full_r;
    tuple_pair_t   even_hold_r;
    logic [AW-1:0] ping_addr_r;
    tuple_pair_t   even_data_r, odd_data_r;
    logic          ping_write_en_r;
    logic [31:0]   stream_len_r;
    logic          load_done_r;
    logic          overflow_r;

    logic          ready_s, xfer_s, wr_req_s, clear_s, set_ovf_s;
    tuple_pair_t   wr_even_s, wr_odd_s;

    assign wr_addr_plus2_s = wr_addr_r + ADDR_STEP;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state decode plus write/transfer strobes.
    always_comb begin
        state_next = state_r;
        ready_s    = 1'b0;
        xfer_s     = 1'b0;
        wr_req_s   = 1'b0;
        clear_s    = 1'b0;
        set_ovf_s  = 1'b0;
        wr_even_s  = even_hold_r;
        wr_odd_s   = ALL_ONES;
        case (state_r)
            IDLE: begin
                if (start_in) begin
                    state_next = ACCEPT;
                    clear_s    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCEPT: begin
                ready_s = (count_r < MAX_COUNT);
                if (ready_s && tuple_valid_in) begin
                    xfer_s = 1'b1;
                    if (half_full_r) begin
                        wr_req_s   = 1'b1;
                        wr_odd_s   = tuple_in;
                        state_next = tuple_last_in ? TAIL : ACCEPT;
                    end else if (tuple_last_in) begin
                        // Odd total: the fill pair goes out in the same slot a pair would.
                        wr_req_s   = 1'b1;
                        wr_even_s  = tuple_in;
                        state_next = TAIL;
                    end else begin
                        state_next = ACCEPT;
                    end
                end else if (!ready_s && tuple_valid_in) begin
                    set_ovf_s  = 1'b1;
                    state_next = DONE;
                end else if (!ready_s && tuple_last_in) begin
                    state_next = DONE;
                end else begin
                    state_next = ACCEPT;
                end
            end
`ifdef AOC5_LOAD_PAD_EN
            PAD: begin
                if (wr_addr_r[3:0] == 4'd0) begin
                    state_next = DONE;
                end else begin
                    wr_req_s   = 1'b1;
                    wr_even_s  = ALL_ONES;
                    wr_odd_s   = ALL_ONES;
                    state_next = (wr_addr_plus2_s[3:0] == 4'd0) ? DONE : PAD;
                end
            end
`endif
            DONE: begin
                if (start_in) begin
                    state_next = ACCEPT;
                    clear_s    = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: hold register, counters, registered write port and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r         <= 32'd0;
            wr_addr_r       <= '0;
            half_full_r     <= 1'b0;
            even_hold_r     <= '0;
            ping_addr_r     <= '0;
            even_data_r     <= '0;
            odd_data_r      <= '0;
            ping_write_en_r <= 1'b0;
            stream_len_r    <= 32'd0;
            load_done_r     <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            ping_write_en_r <= wr_req_s;
            // Done lags DONE entry by a cycle so the final write has retired.
            load_done_r     <= (state_r == DONE) && (state_next == DONE);
            if (clear_s) begin
                count_r      <= 32'd0;
                wr_addr_r    <= '0;
                half_full_r  <= 1'b0;
                stream_len_r <= 32'd0;
                overflow_r   <= 1'b0;
            end else begin
                if (set_ovf_s) begin
                    overflow_r <= 1'b1;
                end
                if (xfer_s) begin
                    count_r      <= count_r + 32'd1;
                    stream_len_r <= (count_r + 32'd1 > MAX_COUNT) ? MAX_COUNT : count_r + 32'd1;
                    half_full_r  <= !half_full_r && !tuple_last_in;
                    if (!half_full_r) begin
                        even_hold_r <= tuple_in;
                    end
                end
                if (wr_req_s) begin
                    ping_addr_r <= wr_addr_r;
                    even_data_r <= wr_even_s;
                    odd_data_r  <= wr_odd_s;
                    wr_addr_r   <= wr_addr_plus2_s;
                end
            end
        end
    end

    assign tuple_ready_out = ready_s;
    assign ping_addr_out   = ping_addr_r;
    assign even_data_out   = even_data_r;
    assign odd_data_out    = odd_data_r;
    assign ping_write_en   = ping_write_en_r;
    assign stream_len_out  = stream_len_r;
    assign load_done_out   = load_done_r;
    assign overflow_out    = overflow_r;

endmodule

// File: tb/tb_aoc5_load_phase.sv
// Scoreboard bench for aoc5_load_phase: directed loads, expected writes queued, monitor pops on each write.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 12
`endif

module tb_aoc5_load_phase;
    import aoc5_load_pkg::*;

    localparam int MAXT = 16;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic                        clock = 1'b0;
    logic                        reset;
    logic                        start_in;
    tuple_pair_t                 tuple_in;
    logic                        tuple_valid_in;
    logic                        tuple_last_in;
    logic                        tuple_ready_out;
    logic [`BANK_ADDR_WIDTH-1:0] ping_addr_out;
    tuple_pair_t                 even_data_out;
    tuple_pair_t                 odd_data_out;
    logic                        ping_write_en;
    logic [31:0]                 stream_len_out;
    logic                        load_done_out;
    logic                        overflow_out;

    int total = 0;
    int bad = 0;
    logic [95:0] exp_q[$];
    logic [95:0] mon_got;
    logic [95:0] mon_exp;

    aoc5_load_phase #(.MAX_TUPLES(MAXT)) dut (
        .clock(clock), .reset(reset), .start_in(start_in),
        .tuple_in(tuple_in), .tuple_valid_in(tuple_valid_in), .tuple_last_in(tuple_last_in),
        .tuple_ready_out(tuple_ready_out), .ping_addr_out(ping_addr_out),
        .even_data_out(even_data_out), .odd_data_out(odd_data_out),
        .ping_write_en(ping_write_en), .stream_len_out(stream_len_out),
        .load_done_out(load_done_out), .overflow_out(overflow_out)
    );

    always #5 clock = ~clock;

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset && ping_write_en) begin
            mon_got = {32'(ping_addr_out), even_data_out, odd_data_out};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%0d even=%h odd=%h, required no write",
                         ping_addr_out, even_data_out, odd_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL write_data: got %h, required %h", mon_got, mon_exp);
                end
            end
            total++;
            if (load_done_out !== 1'b0) begin
                bad++;
                $display("FAIL done_during_write: got load_done=%b, required 0", load_done_out);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic exp_write(input int addr, input logic [31:0] e, input logic [31:0] o);
        exp_q.push_back({32'(addr), e, o});
    endtask

    task automatic exp_pads(input int from);
`ifdef AOC5_LOAD_PAD_EN
        for (int a = from; (a % 16) != 0; a += 2) begin
            exp_write(a, ONES, ONES);
        end
`else
        if (from < 0) begin
            exp_write(from, ONES, ONES);
        end
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_in = 1'b0;
        tuple_valid_in = 1'b0;
        tuple_last_in = 1'b0;
        tuple_in = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(posedge clock);
        #1;
        start_in = 1'b0;
    endtask

    task automatic send_item(input logic [31:0] d, input logic last);
        int n = 0;
        tuple_in = d;
        tuple_last_in = last;
        tuple_valid_in = 1'b1;
        while (!tuple_ready_out && n < 32) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 32) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready=0 for %0d cycles, required ready=1", n);
        end
        @(posedge clock);
        #1;
        tuple_last_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!load_done_out && n < 64) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, {31'd0, load_done_out}, 32'd1);
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_ready", {31'd0, tuple_ready_out}, 32'd0);
        check("rst_wen", {31'd0, ping_write_en}, 32'd0);
        check("rst_done", {31'd0, load_done_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow_out}, 32'd0);
        check("rst_len", stream_len_out, 32'd0);
        check("rst_addr", 32'(ping_addr_out), 32'd0);

        // Four items back to back.
        exp_write(0, 32'hA000_0001, 32'hB000_0002);
        exp_write(2, 32'hC000_0003, 32'hD000_0004);
        exp_pads(4);
        pulse_start();
        check("accept_ready", {31'd0, tuple_ready_out}, 32'd1);
        send_item(32'hA000_0001, 1'b0);
        send_item(32'hB000_0002, 1'b0);
        send_item(32'hC000_0003, 1'b0);
        send_item(32'hD000_0004, 1'b1);
        tuple_valid_in = 1'b0;
        check("t4_len", stream_len_out, 32'd4);
        wait_done("t4_done");
        check("t4_ovf", {31'd0, overflow_out}, 32'd0);
        check("t4_ready_done", {31'd0, tuple_ready_out}, 32'd0);

        // Restart from DONE with an odd-length load.
        exp_write(0, 32'h1111_0001, 32'h2222_0002);
        exp_write(2, 32'h3333_0003, ONES);
        exp_pads(4);
        pulse_start();
        check("restart_done_drop", {31'd0, load_done_out}, 32'd0);
        send_item(32'h1111_0001, 1'b0);
        send_item(32'h2222_0002, 1'b0);
        send_item(32'h3333_0003, 1'b1);
        tuple_valid_in = 1'b0;
        check("t3_len", stream_len_out, 32'd3);
        wait_done("t3_done");

        // Sixteen items, valid toggling; full capacity, already aligned.
        for (int i = 0; i < 16; i += 2) begin
            exp_write(i, 32'h5500_0000 + 32'(i), 32'h5500_0000 + 32'(i + 1));
        end
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_item(32'h5500_0000 + 32'(i), (i == 15) ? 1'b1 : 1'b0);
            tuple_valid_in = 1'b0;
            @(posedge clock);
            #1;
        end
        wait_done("t16_done");
        check("t16_len", stream_len_out, 32'd16);
        check("t16_ovf", {31'd0, overflow_out}, 32'd0);

        // Seventeen items without last: overflow.
        for (int i = 0; i < 16; i += 2) begin
            exp_write(i, 32'h7700_0000 + 32'(i), 32'h7700_0000 + 32'(i + 1));
        end
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_item(32'h7700_0000 + 32'(i), 1'b0);
        end
        check("full_ready_low", {31'd0, tuple_ready_out}, 32'd0);
        check("full_ovf_pre", {31'd0, overflow_out}, 32'd0);
        tuple_in = 32'h7700_0010;
        @(posedge clock);
        #1;
        tuple_valid_in = 1'b0;
        check("ovf_set", {31'd0, overflow_out}, 32'd1);
        wait_done("ovf_done");
        check("ovf_len", stream_len_out, 32'd16);

        // Reset mid-load after five items.
        exp_write(0, 32'h9900_0000, 32'h9900_0001);
        exp_write(2, 32'h9900_0002, 32'h9900_0003);
        pulse_start();
        check("t5_ovf_cleared", {31'd0, overflow_out}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            send_item(32'h9900_0000 + 32'(i), 1'b0);
        end
        tuple_valid_in = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_ready", {31'd0, tuple_ready_out}, 32'd0);
        check("mid_rst_wen", {31'd0, ping_write_en}, 32'd0);
        check("mid_rst_len", stream_len_out, 32'd0);
        check("mid_rst_addr", 32'(ping_addr_out), 32'd0);
        check("mid_rst_done", {31'd0, load_done_out}, 32'd0);
        check("mid_rst_q", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_ready", {31'd0, tuple_ready_out}, 32'd0);
        exp_write(0, 32'hEE00_0001, 32'hEE00_0002);
        exp_pads(2);
        pulse_start();
        send_item(32'hEE00_0001, 1'b0);
        send_item(32'hEE00_0002, 1'b1);
        tuple_valid_in = 1'b0;
        wait_done("t2_done");
        check("t2_len", stream_len_out, 32'd2);

        repeat (3) begin
            @(posedge clock);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
